// File: rtl/agu_lsu_exec_unit_if.sv
// agu_lsu_exec_unit_if: data-memory req/ack bus plus CDB req/grant publish port of the load/store unit.
interface agu_lsu_exec_unit_if #(parameter int XLEN = 32, parameter int TAG_W = 6);
  logic             mem_req;
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic [3:0]       mem_be;
  logic             mem_ack;
  logic [XLEN-1:0]  mem_rdata;
  logic             cdb_req;
  logic             cdb_grant;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be, cdb_req, cdb_valid, cdb_tag, cdb_data,
    input  mem_ack, mem_rdata, cdb_grant
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, cdb_req, cdb_valid, cdb_tag, cdb_data,
    output mem_ack, mem_rdata, cdb_grant
  );
endinterface

// File: rtl/agu_lsu_exec_unit.sv
// agu_lsu_exec_unit: single-beat load/store execution with CDB writeback.
// Optional misaligned-access trap when LSU_MISALIGN_CHK_EN is defined.
module agu_lsu_exec_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [XLEN-1:0]  ex_address,
  input  logic [XLEN-1:0]  ex_data,
  input  logic [TAG_W-1:0] rd_tag_in,
  input  logic             rd_tag_valid_in,
  input  logic [2:0]       funct3_in,
  input  logic             agu_ls_in,
  output logic             ex_done,
`ifdef LSU_MISALIGN_CHK_EN
  output logic             misalign_err,
`endif
  agu_lsu_exec_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;
  state_t           state;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic             ls_q, tv_q, mis_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  res_q;
  logic [1:0]       off;
  logic [3:0]       be;
  logic [XLEN-1:0]  wdata, ld;
  logic [15:0]      sh;
  logic             mis, mem_done;
  assign off = ex_address[1:0];
`ifdef LSU_MISALIGN_CHK_EN
  assign mis = funct3_in[1] ? |off : funct3_in[0] & off[0];
  assign misalign_err = ex_done & mis_q;
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    be = funct3_in[1:0] == 2'b00 ? 4'b0001 << off : funct3_in[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    wdata = funct3_in[1:0] == 2'b00 ? {4{ex_data[7:0]}} : funct3_in[1:0] == 2'b01 ? {2{ex_data[15:0]}} : ex_data;
    sh = 16'(bus.mem_rdata >> {off_q, 3'b000});
    ld = f3_q == 3'b000 ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
         f3_q == 3'b001 ? {{(XLEN-16){sh[15]}}, sh} :
         f3_q == 3'b100 ? {{(XLEN-8){1'b0}}, sh[7:0]} :
         f3_q == 3'b101 ? {{(XLEN-16){1'b0}}, sh} : bus.mem_rdata;
    mem_done = state == MEM && (bus.mem_ack || mis_q);
    bus.cdb_valid = state == WB && bus.cdb_grant;
    ex_done = (mem_done && (ls_q || !tv_q)) || bus.cdb_valid;
  end
  assign bus.cdb_tag  = tag_q;
  assign bus.cdb_data = res_q;
  // A trapped access skips the bus: stores and untagged loads retire from MEM, tagged loads go straight to WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.cdb_req   <= 1'b0;
      off_q         <= '0;
      f3_q          <= '0;
      ls_q          <= 1'b0;
      tv_q          <= 1'b0;
      mis_q         <= 1'b0;
      tag_q         <= '0;
      res_q         <= '0;
    end else begin
      case (state)
        IDLE: if (issue_valid) begin
          off_q         <= off;
          f3_q          <= funct3_in;
          ls_q          <= agu_ls_in;
          tv_q          <= rd_tag_valid_in;
          tag_q         <= rd_tag_in;
          mis_q         <= mis;
          res_q         <= '0;
          bus.mem_req   <= !mis;
          bus.mem_we    <= agu_ls_in;
          bus.mem_addr  <= {ex_address[XLEN-1:2], 2'b00};
          bus.mem_be    <= be;
          bus.mem_wdata <= wdata;
          bus.cdb_req   <= mis && !agu_ls_in && rd_tag_valid_in;
          state         <= mis && !agu_ls_in && rd_tag_valid_in ? WB : MEM;
        end
        MEM: if (mem_done) begin
          bus.mem_req <= 1'b0;
          res_q       <= mis_q ? '0 : ld;
          bus.cdb_req <= !ls_q && tv_q;
          state       <= !ls_q && tv_q ? WB : IDLE;
        end
        WB: if (bus.cdb_grant) begin
          bus.cdb_req <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_agu_lsu_exec_unit.sv
// tb_agu_lsu_exec_unit: directed vectors with hand-computed expectations for the load/store unit.
module tb_agu_lsu_exec_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [31:0] ex_address = '0;
  logic [31:0] ex_data = '0;
  logic [5:0]  rd_tag_in = '0;
  logic        rd_tag_valid_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic        agu_ls_in = 1'b0;
  logic        ex_done;
  int          checks = 0;
  int          errors = 0;
`ifdef LSU_MISALIGN_CHK_EN
  logic        misalign_err;
`endif
  agu_lsu_exec_unit_if #(.XLEN(32), .TAG_W(6)) bus ();
  agu_lsu_exec_unit #(.XLEN(32), .TAG_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .ex_address(ex_address),
    .ex_data(ex_data),
    .rd_tag_in(rd_tag_in),
    .rd_tag_valid_in(rd_tag_valid_in),
    .funct3_in(funct3_in),
    .agu_ls_in(agu_ls_in),
    .ex_done(ex_done),
`ifdef LSU_MISALIGN_CHK_EN
    .misalign_err(misalign_err),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic ls, input logic [5:0] t, input logic tv);
    @(negedge clk);
    ex_address = a; ex_data = d; funct3_in = f; agu_ls_in = ls; rd_tag_in = t; rd_tag_valid_in = tv;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask
  initial begin
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.cdb_grant = 1'b0;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_ex_done", 32'(ex_done), 0);
    chk("rst_cdb_req", 32'(bus.cdb_req), 0);
    chk("rst_addr", bus.mem_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // store word, ack on third MEM cycle
    issue(32'h1000_0004, 32'hDEAD_BEEF, 3'b010, 1'b1, 6'h3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.mem_ack = 1'b1;
      #1;
      chk("sw_req", 32'(bus.mem_req), 1);
      chk("sw_we", 32'(bus.mem_we), 1);
      chk("sw_be", 32'(bus.mem_be), 32'hF);
      chk("sw_addr", bus.mem_addr, 32'h1000_0004);
      chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("sw_done", 32'(ex_done), i == 2 ? 1 : 0);
      chk("sw_cdb_req", 32'(bus.cdb_req), 0);
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    #1;
    chk("sw_idle_req", 32'(bus.mem_req), 0);
    chk("sw_idle_done", 32'(ex_done), 0);
    // LB sign-extend from lane 3, immediate grant
    issue(32'h0000_0203, 32'h0, 3'b000, 1'b0, 6'h15, 1'b1);
    chk("lb_be", 32'(bus.mem_be), 32'h8);
    chk("lb_addr", bus.mem_addr, 32'h200);
    chk("lb_we", 32'(bus.mem_we), 0);
    bus.mem_rdata = 32'h80FF_FF7F; bus.mem_ack = 1'b1;
    #1 chk("lb_ack_done", 32'(ex_done), 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("lb_cdb_req", 32'(bus.cdb_req), 1);
    chk("lb_mem_req", 32'(bus.mem_req), 0);
    bus.cdb_grant = 1'b1;
    #1;
    chk("lb_valid", 32'(bus.cdb_valid), 1);
    chk("lb_tag", 32'(bus.cdb_tag), 32'h15);
    chk("lb_data", bus.cdb_data, 32'hFFFF_FF80);
    chk("lb_done", 32'(ex_done), 1);
    @(negedge clk);
    bus.cdb_grant = 1'b0;
    #1;
    chk("lb_post_req", 32'(bus.cdb_req), 0);
    chk("lb_post_valid", 32'(bus.cdb_valid), 0);
    // LHU from upper half, ack in first MEM cycle
    issue(32'h0000_0302, 32'h0, 3'b101, 1'b0, 6'h09, 1'b1);
    chk("lhu_be", 32'(bus.mem_be), 32'hC);
    bus.mem_rdata = 32'hBEEF_1234; bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.cdb_grant = 1'b1;
    #1;
    chk("lhu_data", bus.cdb_data, 32'h0000_BEEF);
    chk("lhu_tag", 32'(bus.cdb_tag), 32'h09);
    chk("lhu_done", 32'(ex_done), 1);
    @(negedge clk);
    bus.cdb_grant = 1'b0;
    // LW with a 5-cycle CDB stall; an issue offered meanwhile must be ignored
    issue(32'h0000_0400, 32'h0, 3'b010, 1'b0, 6'h2A, 1'b1);
    bus.mem_rdata = 32'h1234_5678; bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    ex_address = 32'h0000_0800; funct3_in = 3'b010; agu_ls_in = 1'b1; issue_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req", 32'(bus.cdb_req), 1);
      chk("stall_valid", 32'(bus.cdb_valid), 0);
      chk("stall_done", 32'(ex_done), 0);
      chk("stall_mem_req", 32'(bus.mem_req), 0);
      @(negedge clk);
    end
    issue_valid = 1'b0; bus.cdb_grant = 1'b1;
    #1;
    chk("stall_grant_valid", 32'(bus.cdb_valid), 1);
    chk("stall_grant_data", bus.cdb_data, 32'h1234_5678);
    chk("stall_grant_tag", 32'(bus.cdb_tag), 32'h2A);
    chk("stall_grant_done", 32'(ex_done), 1);
    @(negedge clk);
    bus.cdb_grant = 1'b0;
    #1;
    chk("stall_idle_req", 32'(bus.mem_req), 0);
    chk("stall_idle_addr", bus.mem_addr, 32'h400);
    // SB and SH lane replication
    issue(32'h0000_0101, 32'h0000_00AB, 3'b000, 1'b1, 6'h0, 1'b0);
    chk("sb_be", 32'(bus.mem_be), 32'h2);
    chk("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    bus.mem_ack = 1'b1;
    #1 chk("sb_done", 32'(ex_done), 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    issue(32'h0000_0102, 32'hFFFF_1234, 3'b001, 1'b1, 6'h0, 1'b0);
    chk("sh_be", 32'(bus.mem_be), 32'hC);
    chk("sh_wdata", bus.mem_wdata, 32'h1234_1234);
    bus.mem_ack = 1'b1;
    #1 chk("sh_done", 32'(ex_done), 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    // untagged load retires at ack without a CDB request
    issue(32'h0000_0500, 32'h0, 3'b001, 1'b0, 6'h11, 1'b0);
    bus.mem_rdata = 32'h0000_8001; bus.mem_ack = 1'b1;
    #1 chk("untag_done", 32'(ex_done), 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1 chk("untag_cdb_req", 32'(bus.cdb_req), 0);
    // tagged LH sign-extends bit 15
    issue(32'h0000_0500, 32'h0, 3'b001, 1'b0, 6'h12, 1'b1);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.cdb_grant = 1'b1;
    #1 chk("lh_data", bus.cdb_data, 32'hFFFF_8001);
    @(negedge clk);
    bus.cdb_grant = 1'b0;
    // asynchronous reset in MEM abandons the access
    issue(32'h0000_0600, 32'h0, 3'b010, 1'b0, 6'h01, 1'b1);
    chk("rmid_req_before", 32'(bus.mem_req), 1);
    rst = 1'b0;
    #1;
    chk("rmid_req_after", 32'(bus.mem_req), 0);
    chk("rmid_done", 32'(ex_done), 0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rmid_cdb_req", 32'(bus.cdb_req), 0);
    chk("rmid_idle_req", 32'(bus.mem_req), 0);
    issue(32'h0000_0700, 32'h5555_AAAA, 3'b010, 1'b1, 6'h0, 1'b0);
    chk("rmid_next_addr", bus.mem_addr, 32'h700);
    bus.mem_ack = 1'b1;
    #1 chk("rmid_next_done", 32'(ex_done), 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
    issue(32'h0000_0101, 32'h0, 3'b010, 1'b0, 6'h07, 1'b1);
    chk("mis_mem_req", 32'(bus.mem_req), 0);
    chk("mis_cdb_req", 32'(bus.cdb_req), 1);
    bus.cdb_grant = 1'b1;
    #1;
    chk("mis_data", bus.cdb_data, 0);
    chk("mis_done", 32'(ex_done), 1);
    chk("mis_err", 32'(misalign_err), 1);
    @(negedge clk);
    bus.cdb_grant = 1'b0;
    #1 chk("mis_err_clear", 32'(misalign_err), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/agu_lsu_exec_unit.md
Name: agu_lsu_exec_unit

Overview:
- Load/store execution unit at the issue side of the AGU reservation queue.
- Accepts one issued memory op (effective address, store data, funct3, load/store bit, destination tag) and performs a single-beat data-memory access over a req/ack handshake.
- Loads are sign- or zero-extended and published on the CDB through a req/grant arbiter handshake.
- Pulses ex_done so the queue retires the entry.

Parameters:
- XLEN, 32, data/address width.
- TAG_W, 6, CDB/ROB tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- issue_valid  in  1  queue presents a ready op.
- ex_address  in  XLEN  effective address (op1+imm).
- ex_data  in  XLEN  store data (op2).
- rd_tag_in  in  TAG_W  destination tag.
- rd_tag_valid_in  in  1  destination tag valid.
- funct3_in  in  3  RISC-V width/sign code.
- agu_ls_in  in  1  0=load, 1=store.
- ex_done  out  1  one-cycle retire pulse to queue.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00}).
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory completes request this cycle.
- mem_rdata  in  XLEN  read word, valid with mem_ack.
- cdb_req  out  1  request CDB slot.
- cdb_grant  in  1  arbiter grant.
- cdb_valid  out  1  CDB publish strobe.
- cdb_tag  out  TAG_W  published tag.
- cdb_data  out  XLEN  published data.

Behaviour:
- Reset (rst=0, async): state=IDLE; every output 0; capture registers cleared. Reset mid-access abandons the access, with no ex_done and no cdb_valid.
- FSM states: IDLE, MEM, WB.
- IDLE:
  - On issue_valid=1, register address, data, tag, tag_valid, funct3 and ls, then go to MEM.
  - issue_valid is ignored in every other state; the queue holds the op stable until ex_done.
- MEM:
  - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are driven from registers and held stable until mem_ack.
  - On mem_ack with ls=1 (store): ex_done=1 that cycle, return to IDLE. Stores never touch the CDB.
  - On mem_ack with ls=0 (load): register the extended result.
    - If tag_valid=1, go to WB.
    - If tag_valid=0, pulse ex_done and return to IDLE (result discarded).
  - mem_ack in the request's first cycle is legal (1-cycle memory). Minimum load latency is issue-accept + 1 mem cycle + 1 WB cycle.
- WB:
  - cdb_req=1.
  - In any cycle with cdb_grant=1: cdb_valid=1, cdb_tag=captured tag, cdb_data=result, ex_done=1 (combinational from grant), then next state IDLE.
  - Without grant, hold indefinitely; cdb_valid=0.
- Byte lanes, off = addr[1:0]:
  - funct3 000/100 (B/BU): be=1<<off.
  - funct3 001/101 (H/HU): be=2'b11<<off.
  - funct3 010 (W): be=4'b1111.
  - Store wdata is replicated/shifted into the selected lanes.
  - Load result: rdata>>(8*off), then sign-extend (000, 001) or zero-extend (100, 101) from 8/16 bits. W is passed through.
- Undefined funct3 (011, 110, 111): treated as W.
- Back-to-back: a new issue is accepted earliest the cycle after ex_done.

Optional Feature:
- Macro LSU_MISALIGN_CHK_EN.
- Defined:
  - Adds output misalign_err (1 bit).
  - H/HU with off[0]=1, or W with off≠0, is detected in IDLE on accept. No mem_req is issued. The unit enters WB with cdb_data=0 (load) or pulses ex_done the next cycle (store).
  - misalign_err pulses with ex_done.
- Undefined:
  - No port. Low address bits are used as-is for lane selection; W ignores off.

Test Plan:
- Store word: issue addr=0x1000_0004, data=0xDEADBEEF, funct3=010, ls=1; ack after 3 cycles -> mem_we=1, be=1111, addr=0x1000_0004 held 3 cycles; ex_done pulse on ack cycle; cdb_req never 1.
- LB sign-extend: addr=0x203, rdata=0x80FF_FF7F, tag=0x15, grant immediate -> cdb_valid with tag 0x15, data=0xFFFF_FF80; ex_done same cycle.
- LHU zero-extend, 0-cycle ack: addr=0x302, rdata=0xBEEF_1234 -> be=1100, cdb_data=0x0000_BEEF.
- CDB stall: load completes, cdb_grant low 5 cycles -> cdb_req high 5 cycles, cdb_valid/ex_done 0, then 1 on grant; issue_valid during stall ignored.
- Reset mid-MEM: assert rst low while mem_req=1 -> mem_req=0 immediately (async); no ex_done; next issue after release proceeds normally.
- With LSU_MISALIGN_CHK_EN: LW addr=0x101 -> no mem_req; cdb_data=0, misalign_err=1 with ex_done on grant.
